// File: rtl/sipo_deser16.sv
// sipo_deser16: serial-in parallel-out deserializer with a valid/ready word handoff
// Define SIPO_DESER_PARITY_EN to append an even-parity bit to each frame and drive perr.
module sipo_deser16 #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_valid,
    output logic             si_ready,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    input  logic             o_ready
`ifdef SIPO_DESER_PARITY_EN
    ,
    output logic             perr
`endif
);

`ifdef SIPO_DESER_PARITY_EN
    localparam int F = WIDTH + 1;
`else
    localparam int F = WIDTH;
`endif
    localparam int CW = $clog2(F + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] sreg, shifted;
    logic [CW-1:0]    cnt;
    logic             acc, last;

    assign acc     = si_valid && si_ready;
    assign last    = acc && cnt == CW'(F - 1);
    assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], si} : {si, sreg[WIDTH-1:1]};

    // next state: FULL waits for the consumer, otherwise accepted bits drive the frame forward
    always_comb begin
        nxt = state;
        nxt = (state == FULL) ? (o_ready ? IDLE : FULL) :
              last            ? FULL :
              acc             ? SHIFT : state;
    end

    // state register; handshake flags are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            si_ready <= 1'b1;
            o_valid  <= 1'b0;
        end else begin
            state    <= nxt;
            si_ready <= nxt != FULL;
            o_valid  <= nxt == FULL;
        end
    end

`ifdef SIPO_DESER_PARITY_EN
    // datapath: shift data bits, the trailing parity bit only feeds the check
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            o    <= '0;
            perr <= 1'b0;
        end else begin
            if (acc) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (cnt < CW'(WIDTH))
                    sreg <= shifted;
            end
            if (last) begin
                o    <= sreg;
                perr <= ^sreg ^ si;
            end else if (state == FULL && o_ready) begin
                perr <= 1'b0;
            end
        end
    end
`else
    // datapath: shift every accepted bit, publish the word on the final one
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            o    <= '0;
        end else if (acc) begin
            sreg <= shifted;
            cnt  <= last ? '0 : cnt + 1'b1;
            if (last)
                o <= shifted;
        end
    end
`endif

endmodule

// File: tb/tb_sipo_deser16.sv
// tb_sipo_deser16: directed scoreboard bench for sipo_deser16 (MSB-first and LSB-first instances)
module tb_sipo_deser16;

    logic        clk = 1'b0;
    logic        rst;
    logic        si0, v0, rdy0, ov0, or0;
    logic        si1, v1, rdy1, ov1, or1;
    logic [15:0] o0, o1;
`ifdef SIPO_DESER_PARITY_EN
    logic        perr0, perr1;
    logic        qp0[$];
    logic        qp1[$];
`endif
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    sipo_deser16 #(.WIDTH(16), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .si(si0), .si_valid(v0), .si_ready(rdy0),
        .o(o0), .o_valid(ov0), .o_ready(or0)
`ifdef SIPO_DESER_PARITY_EN
        , .perr(perr0)
`endif
    );

    sipo_deser16 #(.WIDTH(16), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .si(si1), .si_valid(v1), .si_ready(rdy1),
        .o(o1), .o_valid(ov1), .o_ready(or1)
`ifdef SIPO_DESER_PARITY_EN
        , .perr(perr1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send0(input logic b);
        logic acc;
        int n = 0;
        si0 = b;
        v0  = 1'b1;
        do begin
            acc = rdy0;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 64);
        v0 = 1'b0;
        chk("accept0", {31'd0, acc}, 32'd1);
    endtask

    task automatic send1(input logic b);
        logic acc;
        int n = 0;
        si1 = b;
        v1  = 1'b1;
        do begin
            acc = rdy1;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 64);
        v1 = 1'b0;
        chk("accept1", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_word0(input logic [15:0] w, input logic p);
        q0.push_back(w);
`ifdef SIPO_DESER_PARITY_EN
        qp0.push_back(^w ^ p);
`endif
        for (int i = 15; i >= 0; i--) send0(w[i]);
`ifdef SIPO_DESER_PARITY_EN
        send0(p);
`endif
    endtask

    task automatic send_word1_gapped(input logic [15:0] w, input logic p);
        q1.push_back(w);
`ifdef SIPO_DESER_PARITY_EN
        qp1.push_back(^w ^ p);
`endif
        for (int i = 0; i < 16; i++) begin
            send1(w[i]);
            @(posedge clk);
            #1;
        end
`ifdef SIPO_DESER_PARITY_EN
        send1(p);
`endif
    endtask

    // scoreboard: every consumed word must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && ov0 && or0) begin
            chk("sb0_word", {16'd0, o0}, q0.size() ? {16'd0, q0.pop_front()} : 32'hxxxxxxxx);
`ifdef SIPO_DESER_PARITY_EN
            chk("sb0_perr", {31'd0, perr0}, qp0.size() ? {31'd0, qp0.pop_front()} : 32'hxxxxxxxx);
`endif
        end
        if (!rst && ov1 && or1) begin
            chk("sb1_word", {16'd0, o1}, q1.size() ? {16'd0, q1.pop_front()} : 32'hxxxxxxxx);
`ifdef SIPO_DESER_PARITY_EN
            chk("sb1_perr", {31'd0, perr1}, qp1.size() ? {31'd0, qp1.pop_front()} : 32'hxxxxxxxx);
`endif
        end
    end

    initial begin
        rst = 1'b1;
        si0 = 1'b0; v0 = 1'b0; or0 = 1'b1;
        si1 = 1'b0; v1 = 1'b0; or1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_o0", {16'd0, o0}, 32'h0);
        chk("rst_ov0", {31'd0, ov0}, 32'd0);
        chk("rst_rdy0", {31'd0, rdy0}, 32'd1);
        chk("rst_o1", {16'd0, o1}, 32'h0);
        chk("rst_ov1", {31'd0, ov1}, 32'd0);
        chk("rst_rdy1", {31'd0, rdy1}, 32'd1);
`ifdef SIPO_DESER_PARITY_EN
        chk("rst_perr0", {31'd0, perr0}, 32'd0);
`endif

        send_word0(16'hA5C3, ^16'hA5C3);
        chk("msb_valid", {31'd0, ov0}, 32'd1);
        chk("msb_word", {16'd0, o0}, 32'hA5C3);
        chk("msb_full_rdy", {31'd0, rdy0}, 32'd0);
        @(posedge clk);
        #1;
        chk("msb_idle_valid", {31'd0, ov0}, 32'd0);
        chk("msb_idle_rdy", {31'd0, rdy0}, 32'd1);
        chk("msb_hold_o", {16'd0, o0}, 32'hA5C3);

        send_word1_gapped(16'h0001, ^16'h0001);
`ifdef SIPO_DESER_PARITY_EN
        @(posedge clk);
        #1;
`endif
        chk("lsb_idle_valid", {31'd0, ov1}, 32'd0);
        chk("lsb_word", {16'd0, o1}, 32'h0001);

        or0 = 1'b0;
        send_word0(16'h1234, ^16'h1234);
        chk("bp_valid", {31'd0, ov0}, 32'd1);
        si0 = 1'b1;
        v0  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_rdy", {31'd0, rdy0}, 32'd0);
        chk("bp_valid_hold", {31'd0, ov0}, 32'd1);
        chk("bp_word_hold", {16'd0, o0}, 32'h1234);
        or0 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;
        chk("bp_consumed", {31'd0, ov0}, 32'd0);
        chk("bp_rdy_back", {31'd0, rdy0}, 32'd1);
        send_word0(16'hFFFF, ^16'hFFFF);
        chk("bp_second_valid", {31'd0, ov0}, 32'd1);
        chk("bp_second_word", {16'd0, o0}, 32'hFFFF);
        or0 = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) send0(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid", {31'd0, ov0}, 32'd0);
        chk("midrst_rdy", {31'd0, rdy0}, 32'd1);
        chk("midrst_o", {16'd0, o0}, 32'h0);
        send_word0(16'h00FF, ^16'h00FF);
        chk("midrst_word", {16'd0, o0}, 32'h00FF);
        @(posedge clk);
        #1;

`ifdef SIPO_DESER_PARITY_EN
        or0 = 1'b0;
        send_word0(16'h0003, 1'b0);
        chk("par_ok_perr", {31'd0, perr0}, 32'd0);
        or0 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;
        send_word0(16'h0007, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("par_bad_perr", {31'd0, perr0}, 32'd1);
        chk("par_bad_word", {16'd0, o0}, 32'h0007);
        or0 = 1'b1;
        @(posedge clk);
        #1;
        chk("par_cleared", {31'd0, perr0}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("sb0_drained", q0.size(), 32'd0);
        chk("sb1_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
